axis_video_sink: RTL and testbench
==================================

AXIS_VIDEO_SINK -- requirements
Module: axis_video_sink

Interface
REQ-001 SHALL have parameter H_ACTIVE, default h_visible (640), pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default v_visible (480), lines per frame.
REQ-003 SHALL have ports: pixel_clk in 1 (sole clock); reset in 1 (asynchronous, active-high).
REQ-004 SHALL have ports: s_tdata in 24 ({R[23:16],G[15:8],B[7:0]}); s_tvalid in 1; s_tuser in 1 (start of frame); s_tlast in 1 (end of line); s_tready out 1.
REQ-005 SHALL have port sink_en in 1: downstream permits acceptance.
REQ-006 SHALL have ports: pixel_x out 10; pixel_y out 10; rgb_out out 12; pixel_valid out 1.
REQ-007 SHALL have ports: frame_done out 1 (pulse); frame_count out 16; err_sof out 1; err_eol_early out 1; err_eol_late out 1 (all error outputs are one-cycle pulses).

Function
REQ-008 SHALL drive s_tready = sink_en combinationally; handshake (hs) = s_tvalid & s_tready.
REQ-009 SHALL implement states WAIT_SOF and ACTIVE, held in an enumerated state register.
REQ-010 WAIT_SOF: hs with s_tuser=0 SHALL drop the beat with no pixel_valid; hs with s_tuser=1 SHALL accept the beat as (0,0) and enter ACTIVE.
REQ-011 ACTIVE: each hs SHALL increment x; hs at x=H_ACTIVE-1 with s_tlast=1 SHALL set x=0 and y=y+1.
REQ-012 Accepted beats SHALL register pixel_x/pixel_y, rgb_out={R[7:4],G[7:4],B[7:4]}, and pixel_valid=1 one cycle after hs; otherwise pixel_valid=0.
REQ-013 hs at (H_ACTIVE-1, V_ACTIVE-1) with s_tlast=1 SHALL pulse frame_done one cycle later, increment frame_count (16-bit wrap, 0xFFFF->0), and return to WAIT_SOF.
REQ-014 ACTIVE hs with s_tuser=1 at a position other than (0,0) SHALL pulse err_sof, accept the beat as (0,0), and remain ACTIVE.
REQ-015 ACTIVE hs with s_tlast=1 at x<H_ACTIVE-1 SHALL pulse err_eol_early, output the beat, and go to WAIT_SOF.
REQ-016 ACTIVE hs at x=H_ACTIVE-1 with s_tlast=0 SHALL pulse err_eol_late, output the beat, and go to WAIT_SOF.
REQ-017 If s_tuser and s_tlast arrive in the same beat, s_tuser SHALL be evaluated first; then REQ-015 and REQ-016 apply at x=0.
REQ-018 A stalled beat (s_tvalid=1, s_tready=0) SHALL leave all state and counters unchanged.
REQ-019 Coordinates SHALL never exceed H_ACTIVE-1 / V_ACTIVE-1.

Reset
REQ-020 Reset SHALL set state to WAIT_SOF and force x, y, pixel_x, pixel_y, rgb_out, and frame_count to 0.
REQ-021 Reset SHALL force pixel_valid, frame_done, and all error pulses to 0.
REQ-022 Reset asserted mid-frame SHALL abandon the frame; the first accepted beat after release SHALL require s_tuser=1.

Configuration
REQ-023 With AXIS_SINK_ERR_STATS_EN defined, SHALL add outputs sof_err_cnt, eol_early_cnt, and eol_late_cnt (8-bit each, saturating at 255, reset to 0), one increment per corresponding pulse.
REQ-024 Without AXIS_SINK_ERR_STATS_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 h_visible, v_visible, and the sink_state_t enum (WAIT_SOF, ACTIVE) SHALL reside in starsoc_params.
REQ-026 SHALL be a single module with no sub-module; RGB down-conversion SHALL be inline.

Verification
REQ-027 Full 640x480 frame, sink_en=1, correct tuser/tlast -> 307200 pixel_valid pulses, final pixel (639,479), one frame_done, frame_count=1, no error pulses.
REQ-028 Three beats without tuser, then a valid frame -> the first three beats are dropped (no pixel_valid), and the frame completes normally.
REQ-029 tlast at x=100 on line 5 -> err_eol_early one cycle later, state WAIT_SOF, and no pixel_valid until the next tuser.
REQ-030 tuser injected at (200,10) -> err_sof, pixel_x=0 and pixel_y=0 on that beat, and the remaining frame counted from there.
REQ-031 sink_en toggled every 3 cycles during a frame -> s_tready follows sink_en, a held beat is accepted once, and pixel count remains 307200.
REQ-032 Reset pulsed at (320,240) -> all outputs 0 and WAIT_SOF; with AXIS_SINK_ERR_STATS_EN, 300 eol_late events -> eol_late_cnt=255.

Source files
------------

// File: rtl/starsoc_params.sv
// rtl/starsoc_params.sv - shared video timing constants and sink state type
package starsoc_params;
  localparam int h_visible = 640;
  localparam int v_visible = 480;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } sink_state_t;
endpackage

// File: rtl/axis_video_sink.sv
// rtl/axis_video_sink.sv - AXI-Stream video sink: raster tracking, RGB888->RGB444, framing error pulses
// Optional AXIS_SINK_ERR_STATS_EN adds saturating 8-bit error event counters.
module axis_video_sink
  import starsoc_params::*;
#(
  parameter int H_ACTIVE = h_visible,
  parameter int V_ACTIVE = v_visible
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        sink_en,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] rgb_out,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_sof,
  output logic        err_eol_early,
  output logic        err_eol_late
`ifdef AXIS_SINK_ERR_STATS_EN
  ,
  output logic [7:0]  sof_err_cnt,
  output logic [7:0]  eol_early_cnt,
  output logic [7:0]  eol_late_cnt
`endif
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  sink_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [9:0]  cur_x, cur_y;
  logic        hs, take, at_eol;
  logic        done_d, sof_d, early_d, late_d;
  logic        unused_tdata;

  assign s_tready = sink_en;
  assign hs       = s_tvalid & sink_en;
  // A tuser beat restarts the raster at (0,0) before line-end rules are applied
  assign cur_x    = s_tuser ? 10'd0 : x_q;
  assign cur_y    = s_tuser ? 10'd0 : y_q;
  assign take     = hs & (s_tuser | (state_q == ACTIVE));
  assign at_eol   = (cur_x == X_LAST);

  assign unused_tdata = ^{s_tdata[19:16], s_tdata[11:8], s_tdata[3:0]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    sof_d   = 1'b0;
    early_d = 1'b0;
    late_d  = 1'b0;
    if (take) begin
      sof_d = s_tuser && (state_q == ACTIVE) && ((x_q != 10'd0) || (y_q != 10'd0));
      if (at_eol && s_tlast) begin
        x_d = 10'd0;
        if (cur_y == Y_LAST) begin
          done_d  = 1'b1;
          state_d = WAIT_SOF;
          y_d     = 10'd0;
        end else begin
          state_d = ACTIVE;
          y_d     = cur_y + 10'd1;
        end
      end else if (at_eol || s_tlast) begin
        early_d = s_tlast;
        late_d  = ~s_tlast;
        state_d = WAIT_SOF;
        x_d     = 10'd0;
        y_d     = 10'd0;
      end else begin
        state_d = ACTIVE;
        x_d     = cur_x + 10'd1;
        y_d     = cur_y;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_SOF;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      pixel_x       <= 10'd0;
      pixel_y       <= 10'd0;
      rgb_out       <= 12'd0;
      pixel_valid   <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= 16'd0;
      err_sof       <= 1'b0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_valid   <= take;
      frame_done    <= done_d;
      err_sof       <= sof_d;
      err_eol_early <= early_d;
      err_eol_late  <= late_d;
      if (take) begin
        pixel_x <= cur_x;
        pixel_y <= cur_y;
        rgb_out <= {s_tdata[23:20], s_tdata[15:12], s_tdata[7:4]};
      end
      if (done_d) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef AXIS_SINK_ERR_STATS_EN
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sof_err_cnt   <= 8'd0;
      eol_early_cnt <= 8'd0;
      eol_late_cnt  <= 8'd0;
    end else begin
      if (sof_d && (sof_err_cnt != 8'hFF))     sof_err_cnt   <= sof_err_cnt + 8'd1;
      if (early_d && (eol_early_cnt != 8'hFF)) eol_early_cnt <= eol_early_cnt + 8'd1;
      if (late_d && (eol_late_cnt != 8'hFF))   eol_late_cnt  <= eol_late_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_video_sink.sv
// tb/tb_axis_video_sink.sv - self-checking bench for axis_video_sink (small raster)
// Define AXIS_SINK_ERR_STATS_EN to also exercise the error counters.
module tb_axis_video_sink;
  localparam int H = 16;
  localparam int V = 8;

  logic        clk, reset;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, s_tready, sink_en;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb_out;
  logic        pixel_valid, frame_done;
  logic [15:0] frame_count;
  logic        err_sof, err_eol_early, err_eol_late;
`ifdef AXIS_SINK_ERR_STATS_EN
  logic [7:0]  sof_err_cnt, eol_early_cnt, eol_late_cnt;
`endif

  axis_video_sink #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .pixel_clk     (clk),
    .reset         (reset),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tuser       (s_tuser),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .sink_en       (sink_en),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .rgb_out       (rgb_out),
    .pixel_valid   (pixel_valid),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .err_sof       (err_sof),
    .err_eol_early (err_eol_early),
    .err_eol_late  (err_eol_late)
`ifdef AXIS_SINK_ERR_STATS_EN
    ,
    .sof_err_cnt   (sof_err_cnt),
    .eol_early_cnt (eol_early_cnt),
    .eol_late_cnt  (eol_late_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: raster position held as a linear pixel index
  bit          m_in;
  int          m_p, m_fc;
  bit          e_valid, e_done, e_sof, e_early, e_late;
  int          e_x, e_y;
  logic [11:0] e_rgb;
  int          c_sof, c_early, c_late;

  int pv_cnt, done_cnt, err_cnt, last_x, last_y;
  int src_x, src_y;
  bit pending;

  typedef struct {
    bit          v, u, l, en;
    logic [23:0] d;
    bit          ev;
    int          ex, ey;
    logic [11:0] erg;
    bit          esof, eearly, elate;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic model_step(input bit rst, input bit hs, input bit u, input bit l, input logic [23:0] d);
    e_valid = 0; e_done = 0; e_sof = 0; e_early = 0; e_late = 0;
    if (rst) begin
      m_in = 0; m_p = 0; m_fc = 0; e_x = 0; e_y = 0; e_rgb = '0;
      c_sof = 0; c_early = 0; c_late = 0;
      return;
    end
    if (!hs) return;
    if (u) begin
      if (m_in && m_p != 0) e_sof = 1;
      m_p = 0;
      m_in = 1;
    end
    if (!m_in) return;
    e_valid = 1;
    e_x = m_p % H;
    e_y = m_p / H;
    e_rgb = {d[23:20], d[15:12], d[7:4]};
    if (m_p % H == H - 1) begin
      if (!l) begin
        e_late = 1; m_in = 0;
      end else if (m_p == H * V - 1) begin
        e_done = 1; m_fc = (m_fc + 1) % 65536; m_in = 0;
      end else m_p++;
    end else if (l) begin
      e_early = 1; m_in = 0;
    end else m_p++;
    if (e_sof)   c_sof   = sat(c_sof);
    if (e_early) c_early = sat(c_early);
    if (e_late)  c_late  = sat(c_late);
  endtask

  task automatic cycle(output bit hs);
    chk("s_tready", 32'(s_tready), 32'(sink_en));
    hs = s_tvalid && sink_en && !reset;
    model_step(reset, hs, s_tuser, s_tlast, s_tdata);
    @(posedge clk);
    #1;
    chk("pixel_valid", 32'(pixel_valid), 32'(e_valid));
    if (e_valid) begin
      chk("pixel_x", 32'(pixel_x), 32'(e_x));
      chk("pixel_y", 32'(pixel_y), 32'(e_y));
      chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    end
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("err_sof", 32'(err_sof), 32'(e_sof));
    chk("err_eol_early", 32'(err_eol_early), 32'(e_early));
    chk("err_eol_late", 32'(err_eol_late), 32'(e_late));
`ifdef AXIS_SINK_ERR_STATS_EN
    chk("sof_err_cnt", 32'(sof_err_cnt), 32'(c_sof));
    chk("eol_early_cnt", 32'(eol_early_cnt), 32'(c_early));
    chk("eol_late_cnt", 32'(eol_late_cnt), 32'(c_late));
`endif
    if (pixel_valid) begin
      pv_cnt++; last_x = int'(pixel_x); last_y = int'(pixel_y);
    end
    if (frame_done) done_cnt++;
    if (err_sof || err_eol_early || err_eol_late) err_cnt++;
  endtask

  task automatic clear_stats();
    pv_cnt = 0; done_cnt = 0; err_cnt = 0; last_x = -1; last_y = -1;
  endtask

  task automatic src_restart();
    src_x = 0; src_y = 0; pending = 0;
  endtask

  task automatic do_reset();
    bit hs;
    reset = 1; s_tvalid = 0; s_tuser = 0; s_tlast = 0; sink_en = 1;
    cycle(hs);
    cycle(hs);
    reset = 0;
    src_restart();
  endtask

  // Source that follows the AXI-Stream hold rule; optional tuser/tlast corruption
  task automatic run_stream(input int ncyc, input int vpct, input int epct, input int en_mode, input bit stop_on_done);
    bit hs;
    for (int c = 0; c < ncyc; c++) begin
      if (!pending) begin
        if ($urandom_range(99) < vpct) begin
          s_tvalid = 1;
          s_tuser  = (src_x == 0 && src_y == 0);
          s_tlast  = (src_x == H - 1);
          s_tdata  = 24'($urandom);
          if ($urandom_range(99) < epct) begin
            if ($urandom_range(1) == 0) s_tuser = 1;
            else s_tlast = ~s_tlast;
          end
          pending = 1;
        end else begin
          s_tvalid = 0; s_tuser = 1'($urandom); s_tlast = 1'($urandom); s_tdata = 24'($urandom);
        end
      end
      case (en_mode)
        0: sink_en = 1'($urandom);
        1: sink_en = 1;
        default: sink_en = ((c / 3) % 2 == 0);
      endcase
      cycle(hs);
      if (hs) begin
        pending = 0;
        src_x++;
        if (src_x == H) begin
          src_x = 0; src_y = (src_y + 1) % V;
        end
      end
      if (stop_on_done && done_cnt > 0) break;
    end
  endtask

  task automatic beat(input bit u, input bit l);
    bit hs;
    s_tvalid = 1; s_tuser = u; s_tlast = l; sink_en = 1; s_tdata = 24'($urandom);
    cycle(hs);
  endtask

  initial begin
    bit hs;
    tbl[0]  = '{1, 0, 0, 1, 24'h102030, 0, 0, 0, 12'h000, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 24'h405060, 0, 0, 0, 12'h000, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 24'h708090, 0, 0, 0, 12'h000, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 24'hA1B2C3, 0, 0, 0, 12'h000, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 1, 24'hA1B2C3, 1, 0, 0, 12'hABC, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 24'hFFFFFF, 0, 0, 0, 12'h000, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 24'h1F2E3D, 1, 1, 0, 12'h123, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 24'hF0E0D0, 1, 0, 0, 12'hFED, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 1, 24'h89ABCD, 1, 1, 0, 12'h8AC, 0, 1, 0};
    tbl[9]  = '{1, 0, 0, 1, 24'h000000, 0, 0, 0, 12'h000, 0, 0, 0};
    tbl[10] = '{1, 1, 1, 1, 24'h5A6B7C, 1, 0, 0, 12'h567, 0, 1, 0};
    tbl[11] = '{1, 0, 0, 1, 24'h111111, 0, 0, 0, 12'h000, 0, 0, 0};

    s_tdata = '0;
    clear_stats();
    do_reset();
    chk("rst pixel_x", 32'(pixel_x), 0);
    chk("rst pixel_y", 32'(pixel_y), 0);
    chk("rst rgb_out", 32'(rgb_out), 0);
    chk("rst frame_count", 32'(frame_count), 0);

    // Dropped pre-SOF beats, stall, mid-line SOF, early EOL, tuser+tlast together
    for (int i = 0; i < 12; i++) begin
      s_tvalid = tbl[i].v; s_tuser = tbl[i].u; s_tlast = tbl[i].l;
      sink_en = tbl[i].en; s_tdata = tbl[i].d;
      cycle(hs);
      chk($sformatf("tbl%0d valid", i), 32'(pixel_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d x", i), 32'(pixel_x), 32'(tbl[i].ex));
        chk($sformatf("tbl%0d y", i), 32'(pixel_y), 32'(tbl[i].ey));
        chk($sformatf("tbl%0d rgb", i), 32'(rgb_out), 32'(tbl[i].erg));
      end
      chk($sformatf("tbl%0d sof", i), 32'(err_sof), 32'(tbl[i].esof));
      chk($sformatf("tbl%0d early", i), 32'(err_eol_early), 32'(tbl[i].eearly));
      chk($sformatf("tbl%0d late", i), 32'(err_eol_late), 32'(tbl[i].elate));
    end

    // Clean full-throughput frame
    do_reset();
    clear_stats();
    run_stream(H * V, 100, 0, 1, 0);
    chk("full pixels", 32'(pv_cnt), 32'(H * V));
    chk("full last_x", 32'(last_x), 32'(H - 1));
    chk("full last_y", 32'(last_y), 32'(V - 1));
    chk("full done", 32'(done_cnt), 1);
    chk("full frame_count", 32'(frame_count), 1);
    chk("full errors", 32'(err_cnt), 0);

    // Backpressure toggling every 3 cycles
    clear_stats();
    src_restart();
    run_stream(6 * H * V, 100, 0, 2, 1);
    chk("toggle pixels", 32'(pv_cnt), 32'(H * V));
    chk("toggle done", 32'(done_cnt), 1);
    chk("toggle frame_count", 32'(frame_count), 2);

    // Early tlast at x=10 on line 5, then no output until the next tuser
    src_restart();
    run_stream(5 * H + 10, 100, 0, 1, 0);
    beat(0, 1);
    chk("early pulse", 32'(err_eol_early), 1);
    for (int i = 0; i < 5; i++) begin
      beat(0, 0);
      chk("early dropped", 32'(pixel_valid), 0);
    end

    // Stray tuser at (10,3) restarts the frame from there
    src_restart();
    clear_stats();
    run_stream(3 * H + 10, 100, 0, 1, 0);
    beat(1, 0);
    chk("sof pulse", 32'(err_sof), 1);
    chk("sof x", 32'(pixel_x), 0);
    chk("sof y", 32'(pixel_y), 0);
    src_x = 1; src_y = 0; pending = 0;
    run_stream(H * V - 1, 100, 0, 1, 0);
    chk("sof done", 32'(done_cnt), 1);

    // Randomised traffic with occasional framing corruption
    src_restart();
    run_stream(3000, 70, 3, 0, 0);

    // Mid-frame asynchronous reset at (8,4)
    do_reset();
    run_stream((V / 2) * H + H / 2, 100, 0, 1, 0);
    s_tvalid = 0;
    reset = 1;
    #1;
    chk("arst pixel_valid", 32'(pixel_valid), 0);
    chk("arst pixel_x", 32'(pixel_x), 0);
    chk("arst pixel_y", 32'(pixel_y), 0);
    chk("arst rgb_out", 32'(rgb_out), 0);
    chk("arst frame_count", 32'(frame_count), 0);
    cycle(hs);
    reset = 0;
    src_restart();
    beat(0, 0);
    chk("post-rst drop", 32'(pixel_valid), 0);
    beat(1, 0);
    chk("post-rst sof", 32'(pixel_valid), 1);

`ifdef AXIS_SINK_ERR_STATS_EN
    do_reset();
    for (int e = 0; e < 300; e++)
      for (int i = 0; i < H; i++) beat(i == 0, 0);
    chk("late_cnt sat", 32'(eol_late_cnt), 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
